// File: rtl/mul_sequencer.sv
// Multi-cycle multiply sequencer for the EX stage. It captures the MUL operands,
// stalls the front of the pipe for LATENCY cycles, then presents the product for one cycle.
module mul_sequencer #(
    parameter int          WIDTH   = 32,
    parameter int          LATENCY = 2,
    parameter logic [3:0]  MUL_OP  = 4'd8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid_i,
    input  logic [3:0]       alu_control_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             result_valid_o,
    output logic [WIDTH-1:0] result_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] cap_a_q, cap_b_q;
    logic [WIDTH-1:0] result_q;
    logic             start;
    logic             load_result;
    logic [WIDTH-1:0] mul_a, mul_b;
    logic [WIDTH-1:0] product;

    // A MUL held in reset is not a start; the pipeline is not running yet.
    assign start = ex_valid_i && (alu_control_i == MUL_OP) && (state_q == IDLE)
                   && !flush_i && !rst;

    // With LATENCY==1 the product is loaded straight from the IDLE cycle,
    // before the captured copies exist, so use the live operands there.
    assign mul_a   = (state_q == IDLE) ? operand_a_i : cap_a_q;
    assign mul_b   = (state_q == IDLE) ? operand_b_i : cap_b_q;
    assign product = mul_a * mul_b;

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        stall_o        = 1'b0;
        result_valid_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 1) ? DONE : BUSY;
                    stall_o = 1'b1;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1)
                    state_d = DONE;
            end
            DONE: begin
                result_valid_o = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A redirect kills the MUL wherever it is; the old result stays visible.
        if (flush_i) begin
            state_d        = IDLE;
            stall_o        = 1'b0;
            result_valid_o = 1'b0;
        end
    end

    assign load_result = (state_d == DONE);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cap_a_q  <= '0;
            cap_b_q  <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start) begin
                cap_a_q <= operand_a_i;
                cap_b_q <= operand_b_i;
            end
            if (load_result)
                result_q <= product;
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign result_o = result_q;

endmodule
